// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller and its MD busy tracker.
// Holds the MD sequencer states, MD start encodings, the "source unused" Tuse code and default latencies.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// MD-unit busy sequencer: a start seen in IDLE keeps md_busy high for MULT_CYCLES or DIV_CYCLES cycles.
// md_busy is registered, rising one edge after the start; starts seen while busy or with illegal codes are dropped.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] md_start,
  output logic       md_busy
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (is_mult_op(md_start)) begin
          w_state_nxt = MULT;
          w_cnt_nxt   = CW'(MULT_CYCLES - 1);
        end else if (is_div_op(md_start)) begin
          w_state_nxt = DIV;
          w_cnt_nxt   = CW'(DIV_CYCLES - 1);
        end
      end
      MULT, DIV: begin
        // a committed operation always runs to completion, flushes included
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = (r_state != IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational pause from Tuse/Tnew dependencies and MD busy, plus flush-gated md_start.
// Zero latency on pause/md_start; a flush overrides any stall. HAZARD_STAT_EN adds the saturating stall_count port.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_md_op,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic        E_RegWrite,
  input  logic        M_RegWrite,
  input  logic [1:0]  E_T_new,
  input  logic [1:0]  M_T_new,
  input  logic [2:0]  E_start,
  input  logic        IntReq,
  input  logic        EXLClr,
  output logic        pause,
  output logic [2:0]  md_start,
  output logic        md_busy
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  logic w_flush;
  logic w_stall_reg;
  logic w_stall_md;
  logic w_pause;

  function automatic logic dep_hit(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic we, input logic [4:0] a3, input logic [1:0] tnew);
    return we && (a3 != 5'd0) && (a3 == src) && (tuse != TUSE_NONE) && (tuse < tnew);
  endfunction

  assign w_flush     = IntReq || EXLClr;
  assign md_start    = w_flush ? MD_NONE : E_start;

  assign w_stall_reg = dep_hit(D_rs, D_Tuse_rs, E_RegWrite, E_A3, E_T_new) ||
                       dep_hit(D_rs, D_Tuse_rs, M_RegWrite, M_A3, M_T_new) ||
                       dep_hit(D_rt, D_Tuse_rt, E_RegWrite, E_A3, E_T_new) ||
                       dep_hit(D_rt, D_Tuse_rt, M_RegWrite, M_A3, M_T_new);

  assign w_stall_md  = D_md_op && (md_busy || (md_start != MD_NONE));
  assign w_pause     = (w_stall_reg || w_stall_md) && !w_flush;
  assign pause       = w_pause;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_tracker (
    .clk      (clk),
    .rst_n    (reset),
    .md_start (md_start),
    .md_busy  (md_busy)
  );

`ifdef HAZARD_STAT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_pause && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model and per-cycle comparison.
// stall_count is exercised only when HAZARD_STAT_EN is defined.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_T_new, M_T_new;
  logic        D_md_op, E_RegWrite, M_RegWrite, IntReq, EXLClr;
  logic [2:0]  E_start;
  logic        pause;
  logic [2:0]  md_start;
  logic        md_busy;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int rem = 0;            // model: busy cycles still owed by the MD unit
  logic [31:0] exp_cnt = 0;
  bit run_cmp = 0;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_md_op(D_md_op), .E_A3(E_A3), .M_A3(M_A3),
    .E_RegWrite(E_RegWrite), .M_RegWrite(M_RegWrite),
    .E_T_new(E_T_new), .M_T_new(M_T_new), .E_start(E_start),
    .IntReq(IntReq), .EXLClr(EXLClr),
    .pause(pause), .md_start(md_start), .md_busy(md_busy)
`ifdef HAZARD_STAT_EN
    , .stall_count(stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic dep(input logic [4:0] s, input logic [1:0] tuse, input logic we,
                               input logic [4:0] a3, input logic [1:0] tnew);
    return we && (a3 != 0) && (a3 == s) && (int'(tuse) < int'(tnew));
  endfunction

  function automatic logic [2:0] m_start();
    return (IntReq || EXLClr) ? 3'd0 : E_start;
  endfunction

  function automatic logic m_pause();
    logic sreg;
    logic smd;
    sreg = dep(D_rs, D_Tuse_rs, E_RegWrite, E_A3, E_T_new) | dep(D_rs, D_Tuse_rs, M_RegWrite, M_A3, M_T_new)
         | dep(D_rt, D_Tuse_rt, E_RegWrite, E_A3, E_T_new) | dep(D_rt, D_Tuse_rt, M_RegWrite, M_A3, M_T_new);
    smd  = D_md_op && ((rem != 0) || (m_start() != 0));
    return (sreg || smd) && !IntReq && !EXLClr;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem     <= 0;
      exp_cnt <= 0;
    end else begin
      if (rem != 0) rem <= rem - 1;
      else if (m_start() == 3'd1 || m_start() == 3'd2) rem <= MULT_N;
      else if (m_start() == 3'd3 || m_start() == 3'd4) rem <= DIV_N;
      if (m_pause() && exp_cnt != 32'hFFFF_FFFF) exp_cnt <= exp_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cyc_pause", {31'd0, pause}, {31'd0, m_pause()});
      chk("cyc_md_start", {29'd0, md_start}, {29'd0, m_start()});
      chk("cyc_md_busy", {31'd0, md_busy}, {31'd0, rem != 0});
`ifdef HAZARD_STAT_EN
      chk("cyc_stall_count", stall_count, exp_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_md_op = 0;
    E_A3 = 0; M_A3 = 0; E_RegWrite = 0; M_RegWrite = 0; E_T_new = 0; M_T_new = 0;
    E_start = 0; IntReq = 0; EXLClr = 0;
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    #2;
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_pause", {31'd0, pause}, 32'd0);
`ifdef HAZARD_STAT_EN
    chk("reset_stall_count", stall_count, 32'd0);
`endif
    run_cmp = 1;
    step(); step();
    reset = 1'b1;
    step();

    // load-use on rs via E
    E_A3 = 8; E_RegWrite = 1; E_T_new = 2; D_rs = 8; D_Tuse_rs = 0;
    #1 chk("loaduse_pause", {31'd0, pause}, 32'd1);
    D_rs = 0; E_A3 = 0;
    #1 chk("reg0_no_pause", {31'd0, pause}, 32'd0);
    step();
    // M-stage on rt: Tuse==Tnew is not a stall, Tuse<Tnew is
    clear_in();
    M_A3 = 5; M_RegWrite = 1; M_T_new = 1; D_rt = 5; D_Tuse_rt = 1;
    #1 chk("m_equal_tuse", {31'd0, pause}, 32'd0);
    D_Tuse_rt = 0;
    #1 chk("m_rt_stall", {31'd0, pause}, 32'd1);
    EXLClr = 1;
    #1 chk("eret_masks", {31'd0, pause}, 32'd0);
    step();
    clear_in();
    step();

    // mult with dependent md op throughout
    D_md_op = 1; E_start = 3'd1;
    #1 chk("mult_k_pause", {31'd0, pause}, 32'd1);
    chk("mult_k_start", {29'd0, md_start}, 32'd1);
    step();
    E_start = 0;
    for (int i = 1; i <= MULT_N; i++) begin
      chk("mult_busy", {31'd0, md_busy}, 32'd1);
      chk("mult_pause", {31'd0, pause}, 32'd1);
      step();
    end
    chk("mult_done_busy", {31'd0, md_busy}, 32'd0);
    chk("mult_done_pause", {31'd0, pause}, 32'd0);

    // killed div never starts
    E_start = 3'd3; IntReq = 1;
    #1 chk("killed_start", {29'd0, md_start}, 32'd0);
    chk("killed_pause", {31'd0, pause}, 32'd0);
    step();
    E_start = 0; IntReq = 0;
    chk("killed_idle", {31'd0, md_busy}, 32'd0);

    // illegal encoding is ignored
    D_md_op = 0; E_start = 3'd6;
    step();
    E_start = 0;
    chk("illegal_idle", {31'd0, md_busy}, 32'd0);

    // div survives an IntReq pulse at k+3 and a stray start while busy
    E_start = 3'd3;
    step();
    E_start = 0;
    step();
    E_start = 3'd1;
    step();
    E_start = 0; IntReq = 1;
    #1 chk("div_int_busy", {31'd0, md_busy}, 32'd1);
    step();
    IntReq = 0;
    for (int c = 4; c <= 10; c++) begin
      chk("div_busy_k", {31'd0, md_busy}, 32'd1);
      step();
    end
    chk("div_done", {31'd0, md_busy}, 32'd0);

    // reset in the middle of a divide
    E_start = 3'd4;
    step();
    E_start = 0;
    step(); step(); step();
    #2 reset = 1'b0;
    #1 chk("midreset_busy", {31'd0, md_busy}, 32'd0);
    step();
    reset = 1'b1;
    E_start = 3'd2;
    step();
    E_start = 0;
    for (int i = 0; i < MULT_N; i++) begin
      chk("post_reset_mult", {31'd0, md_busy}, 32'd1);
      step();
    end
    chk("post_reset_done", {31'd0, md_busy}, 32'd0);

`ifdef HAZARD_STAT_EN
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    E_A3 = 8; E_RegWrite = 1; E_T_new = 2; D_rs = 8; D_Tuse_rs = 0;
    for (int i = 0; i < 7; i++) step();
    clear_in();
    #1 chk("stall_count_7", stall_count, 32'd7);
    step();
`endif

    run_cmp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and multiply/divide sequencing controller for the five-stage MIPS core. It generates the `pause` signal that holds F/D and bubbles the D/E register whenever a decoded instruction cannot issue. The two stall causes are an unresolved register dependency (Tuse/Tnew comparison against E and M) and an in-flight multiply/divide. It also owns the MD-unit busy sequencer and gates the `start` strobe so that a killed instruction never launches an MD operation.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu after start.
- `DIV_CYCLES`, 10: busy cycles for div/divu after start.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `D_rs`, `D_rt`  in  5 each: source register numbers of the D-stage instruction.
- `D_Tuse_rs`, `D_Tuse_rt`  in  2 each: cycles until D needs rs/rt; 3 = not used.
- `D_md_op`  in  1: D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `E_A3`, `M_A3`  in  5 each: destination register in E and in M.
- `E_RegWrite`, `M_RegWrite`  in  1 each: destination write enables.
- `E_T_new`, `M_T_new`  in  2 each: cycles until the result is available.
- `E_start`  in  3: MD request from the D/E register; 0 none, 1 mult, 2 multu, 3 div, 4 divu.
- `IntReq`  in  1: exception/interrupt taken this cycle; kills the E instruction.
- `EXLClr`  in  1: eret flush this cycle.
- `pause`  out  1: stall F/D and insert a D/E bubble.
- `md_start`  out  3: gated start to the MD unit.
- `md_busy`  out  1: MD operation in progress.
- `stall_count`  out  32: only present with `HAZARD_STAT_EN`.

## Operation
Register dependency stall, per source s in {rs, rt}:
- E term: `E_RegWrite` && `E_A3`!=0 && `E_A3`==`D_s` && `D_Tuse_s` < `E_T_new`.
- M term: the same test using `M_RegWrite`, `M_A3` and `M_T_new`.
- `stall_reg` is the OR of all four terms.

MD sequencer FSM, states IDLE, MULT, DIV, with a down-counter `cnt` of width clog2(`DIV_CYCLES`):
- `md_start` = (`IntReq` || `EXLClr`) ? 0 : `E_start`.
- IDLE, `md_start` in {1,2}: go to MULT, load `cnt` = `MULT_CYCLES`-1.
- IDLE, `md_start` in {3,4}: go to DIV, load `cnt` = `DIV_CYCLES`-1.
- IDLE, `md_start` in {5..7}: illegal encoding; ignore it and stay in IDLE.
- MULT/DIV: decrement `cnt` each cycle. When `cnt`==0, return to IDLE on the next edge.
- `md_start` nonzero while in MULT or DIV: ignore it; state and `cnt` are unchanged. Normal issue makes this unreachable.
- `IntReq` or `EXLClr` during MULT/DIV does not abort the operation. The committed op finishes.

MD stall and pause:
- `md_busy` = (state != IDLE).
- `stall_md` = `D_md_op` && (`md_busy` || `md_start`!=0).
- `pause` = (`stall_reg` || `stall_md`) && !`IntReq` && !`EXLClr`. A flush has priority, so a stall never holds a killed instruction.

## Timing
- `pause` and `md_start` are combinational from inputs and registered state. Zero latency.
- Start sampled at edge k: `md_busy` is high for cycles k+1 .. k+N, with N = `MULT_CYCLES` or `DIV_CYCLES`. A dependent md_op issues in cycle k+N+1.
- Reset (any time, including mid-operation): state=IDLE, `cnt`=0, `md_busy`=0, `stall_count`=0. `pause` and `md_start` then follow their combinational inputs.

## Configuration
- `HAZARD_STAT_EN` defined:
  - `stall_count` exists.
  - It increments by 1 on every edge where `pause`=1, and saturates at 32'hFFFFFFFF.
- Undefined: the port and its counter are absent. Everything else is identical.

## Structure
- `hazard_pkg` holds:
  - the MD state enum (IDLE/MULT/DIV);
  - the start encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - TUSE_NONE=3;
  - the default cycle constants.
- One sub-module, `md_busy_tracker`, contains the FSM and counter and exports `md_busy`. The top level holds the dependency comparators and the pause/gating logic.

## Test plan
- Load-use: `E_A3`=8, `E_RegWrite`=1, `E_T_new`=2, `D_rs`=8, `D_Tuse_rs`=0 -> `pause`=1. Change `D_rs` to 0 with `E_A3`=0 -> `pause`=0.
- `E_start`=1 at edge k, `D_md_op`=1 throughout -> `pause` high in cycle k and in k+1..k+5, low at k+6. `md_busy` is high exactly 5 cycles.
- `E_start`=3 with `IntReq`=1 in the same cycle -> `md_start`=0, state stays IDLE, `pause`=0.
- Divide started, then `IntReq` pulsed at k+3 -> `md_busy` stays high until k+10 completes.
- `reset` driven low at k+4 of a divide -> `md_busy`=0 immediately. After release, `E_start`=2 starts a fresh 5-cycle MULT.
- With `HAZARD_STAT_EN`: 7 stalled cycles -> `stall_count`=7. Without it, the bench compiles with no `stall_count` port.
